// File: rtl/mm_pkg.sv
// Shared constants and types for the mm_ctrl result drain path.
package mm_pkg;

    localparam int N_ENTRIES  = 1024;
    localparam int ACC_W      = 24;
    localparam int OUT_LANES  = 4;
    localparam int FIFO_DEPTH = 2;

    localparam int ADDR_W = $clog2(N_ENTRIES);
    localparam int LANE_W = (OUT_LANES > 1) ? $clog2(OUT_LANES) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BEAT_W = OUT_LANES * ACC_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } drain_state_e;

    typedef logic [OUT_LANES-1:0][ACC_W-1:0] beat_t;

    // Lane an accumulator address lands in; lowest address goes to lane 0.
    function automatic logic [LANE_W-1:0] laneOf(input logic [ADDR_W-1:0] addr);
        return (OUT_LANES > 1) ? addr[LANE_W-1:0] : '0;
    endfunction

endpackage

// File: rtl/mm_beat_fifo.sv
// Small synchronous FIFO for packed output beats. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module mm_beat_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pushOk, popOk;

    // Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_count = count_q;
    assign o_data  = mem_q[rdPtr_q];

    // Accept pops only when non-empty and pushes when there is room after the pop.
    always_comb begin
        popOk   = i_pop && !o_empty;
        pushOk  = i_push && (!o_full || popOk);
        wrPtr_d = pushOk ? nextPtr(wrPtr_q) : wrPtr_q;
        rdPtr_d = popOk ? nextPtr(rdPtr_q) : rdPtr_q;
        count_d = count_q;
        if (pushOk && !popOk) begin
            count_d = count_q + 1'b1;
        end else if (popOk && !pushOk) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Beat storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge i_clk) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= i_data;
        end
    end

endmodule

// File: rtl/mm_out_drain.sv
// Drains the accumulator register file after a tile completes and packs
// OUT_LANES results per beat into a valid/ready stream. A new beat is only
// opened when the FIFO plus beats still being assembled leave a free slot,
// so returning read data always has somewhere to go.
module mm_out_drain
    import mm_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_tile_done,
    output logic              o_acc_ren,
    output logic [ADDR_W-1:0] o_acc_raddr,
    input  logic [ACC_W-1:0]  i_acc_rdata,
    output logic              o_valid,
    output logic [BEAT_W-1:0] o_data,
    output logic              o_last,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_drain_done,
    output logic              o_overrun
);

    localparam int                SUM_W     = CNT_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ENTRIES - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(OUT_LANES - 1);

    drain_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rdValid_q, rdLast_q;
    logic [LANE_W-1:0] rdLane_q;
    beat_t             lanes_q, lanes_d, pushBeat;
    logic [CNT_W-1:0]  pend_q, pend_d;
    logic              overrun_q, overrun_d;
    logic              done_q, done_d;
    logic              readEn, openBeat;
    logic              fifoPush, fifoPop, fifoFull, fifoEmpty, headLast;
    logic [CNT_W-1:0]  fifoCount;
    logic [SUM_W-1:0]  reserved;
    logic [BEAT_W:0]   fifoIn, fifoOut;

    assign reserved = {1'b0, fifoCount} + {1'b0, pend_q};
    assign fifoPop  = !fifoEmpty && i_ready;
    assign openBeat = readEn && (laneOf(addr_q) == '0);
    assign headLast = fifoOut[BEAT_W];
    assign fifoIn   = {rdLast_q, pushBeat};

    // Sequencer: tile start, read issue, flush completion and overrun tracking.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        readEn    = 1'b0;
        if (i_tile_done && ((state_q != IDLE) || done_q)) begin
            overrun_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (i_tile_done && !done_q) begin
                    state_d = READ;
                    addr_d  = '0;
                end
            end
            READ: begin
                readEn = !fifoFull &&
                         ((laneOf(addr_q) != '0) || (reserved < SUM_W'(FIFO_DEPTH)));
                if (readEn) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = FLUSH;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (fifoPop && headLast) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane assembly from returning read data and outstanding-beat bookkeeping.
    always_comb begin
        pushBeat = lanes_q;
        fifoPush = 1'b0;
        if (rdValid_q) begin
            pushBeat[rdLane_q] = i_acc_rdata;
            fifoPush           = (rdLane_q == LAST_LANE);
        end
        lanes_d = pushBeat;
        pend_d  = pend_q;
        if (openBeat && !fifoPush) begin
            pend_d = pend_q + 1'b1;
        end else if (fifoPush && !openBeat) begin
            pend_d = pend_q - 1'b1;
        end
    end

    // State registers; reset also drops any read still in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rdValid_q <= 1'b0;
            rdLane_q  <= '0;
            rdLast_q  <= 1'b0;
            lanes_q   <= '0;
            pend_q    <= '0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rdValid_q <= readEn;
            rdLane_q  <= laneOf(addr_q);
            rdLast_q  <= (addr_q == LAST_ADDR);
            lanes_q   <= lanes_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
        end
    end

    mm_beat_fifo #(
        .WIDTH (BEAT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (fifoPush),
        .i_data  (fifoIn),
        .i_pop   (fifoPop),
        .o_data  (fifoOut),
        .o_full  (fifoFull),
        .o_empty (fifoEmpty),
        .o_count (fifoCount)
    );

    assign o_acc_ren    = readEn;
    assign o_acc_raddr  = addr_q;
    assign o_valid      = !fifoEmpty;
    assign o_data       = fifoEmpty ? '0 : fifoOut[BEAT_W-1:0];
    assign o_last       = !fifoEmpty && headLast;
    assign o_busy       = (state_q != IDLE);
    assign o_drain_done = done_q;
    assign o_overrun    = overrun_q;

endmodule
